// File: rtl/zap_wb_pkg.sv
// Shared Wishbone arbiter types and cycle-type encodings.
// No logic; imported by the arbiter and its round-robin picker.
// No flow control; declarations only.
package zap_wb_pkg;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} wb_arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // A beat with one of these cycle types is the last beat of its transfer.
    function automatic logic cti_ends_burst(input logic [2:0] cti);
        return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
    endfunction

endpackage

// File: rtl/zap_rr_pick.sv
// Rotating priority encoder: first set req bit scanning ptr, ptr+1, ... mod N.
// Purely combinational, zero latency.
// No flow control; valid is simply the OR of req.
module zap_rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic             valid,
    output logic [PTR_W-1:0] idx
);
    logic [N-1:0] rot;

    // Bit k of rot is the request of master (ptr + k) mod N.
    assign rot = N'({req, req} >> ptr);

    always_comb begin
        valid = |req;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = PTR_W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/zap_wb_rr_arbiter.sv
// Burst-aware round-robin Wishbone B3 arbiter sharing one bus among N masters.
// Request-to-bus 1 cycle (registered outputs); ack routed back combinationally.
// Grant held until CLASSIC/EOB ack or owner drops cyc; other masters wait unbounded.
module zap_wb_rr_arbiter
    import zap_wb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int PTR_W       = $clog2(NUM_MASTERS)
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [NUM_MASTERS-1:0]       i_m_wb_cyc,
    input  logic [NUM_MASTERS-1:0]       i_m_wb_stb,
    input  logic [NUM_MASTERS-1:0]       i_m_wb_wen,
    input  logic [NUM_MASTERS-1:0][3:0]  i_m_wb_sel,
    input  logic [NUM_MASTERS-1:0][31:0] i_m_wb_dat,
    input  logic [NUM_MASTERS-1:0][31:0] i_m_wb_adr,
    input  logic [NUM_MASTERS-1:0][2:0]  i_m_wb_cti,
    output logic [NUM_MASTERS-1:0]       o_m_wb_ack,
    output logic                         o_wb_cyc,
    output logic                         o_wb_stb,
    output logic                         o_wb_wen,
    output logic [3:0]                   o_wb_sel,
    output logic [31:0]                  o_wb_dat,
    output logic [31:0]                  o_wb_adr,
    output logic [2:0]                   o_wb_cti,
    input  logic                         i_wb_ack,
    output logic [NUM_MASTERS-1:0]       o_grant
);
    localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

    wb_arb_state_t    state;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] rr_ptr;
    logic             pick_vld;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] src;
    logic             routed_ack;
    logic             release_now;

    zap_rr_pick #(.N(NUM_MASTERS), .PTR_W(PTR_W)) u_pick (
        .req   (i_m_wb_stb),
        .ptr   (rr_ptr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    // Only a beat actually presented on the bus can be acked; stray acks are dropped.
    assign routed_ack  = !i_reset && (state == BUSY) && o_wb_stb && i_wb_ack;
    assign o_m_wb_ack  = routed_ack ? (ONE_HOT0 << owner) : '0;
    assign release_now = (state == BUSY) &&
                         ((routed_ack && cti_ends_burst(o_wb_cti)) || !i_m_wb_cyc[owner]);

    // Bus fields come from the winner when granting, from the owner otherwise.
    assign src = (state == IDLE) ? pick_idx : owner;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            o_grant  <= '0;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_wen <= 1'b0;
            o_wb_sel <= '0;
            o_wb_dat <= '0;
            o_wb_adr <= '0;
            o_wb_cti <= '0;
        end else if (state == IDLE) begin
            if (pick_vld) begin
                state    <= BUSY;
                owner    <= pick_idx;
                o_grant  <= ONE_HOT0 << pick_idx;
                o_wb_cyc <= i_m_wb_cyc[src];
                o_wb_stb <= i_m_wb_stb[src];
                o_wb_wen <= i_m_wb_wen[src];
                o_wb_sel <= i_m_wb_sel[src];
                o_wb_dat <= i_m_wb_dat[src];
                o_wb_adr <= i_m_wb_adr[src];
                o_wb_cti <= i_m_wb_cti[src];
            end
        end else if (release_now) begin
            state    <= IDLE;
            o_grant  <= '0;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            rr_ptr   <= (owner == PTR_W'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;
        end else begin
            o_wb_cyc <= i_m_wb_cyc[src];
            // The beat just acked must not be presented a second time.
            o_wb_stb <= i_m_wb_stb[src] && !routed_ack;
            o_wb_wen <= i_m_wb_wen[src];
            o_wb_sel <= i_m_wb_sel[src];
            o_wb_dat <= i_m_wb_dat[src];
            o_wb_adr <= i_m_wb_adr[src];
            o_wb_cti <= i_m_wb_cti[src];
        end
    end

endmodule

// File: tb/tb_zap_wb_rr_arbiter.sv
// Bench for zap_wb_rr_arbiter: directed scenarios plus random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_zap_wb_rr_arbiter;
    import zap_wb_pkg::*;

    localparam int N = 4;

    logic              clk;
    logic              rst;
    logic [N-1:0]      cyc, stb, wen;
    logic [N-1:0][3:0] sel;
    logic [N-1:0][31:0] dat, adr;
    logic [N-1:0][2:0] cti;
    logic              wb_ack;

    logic [N-1:0]      o_m_wb_ack;
    logic              o_wb_cyc, o_wb_stb, o_wb_wen;
    logic [3:0]        o_wb_sel;
    logic [31:0]       o_wb_dat, o_wb_adr;
    logic [2:0]        o_wb_cti;
    logic [N-1:0]      o_grant;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner is -1 when the bus is free.
    int          m_owner;
    int          m_ptr;
    logic        m_cyc, m_stb, m_wen;
    logic [3:0]  m_sel;
    logic [31:0] m_dat, m_adr;
    logic [2:0]  m_cti;

    zap_wb_rr_arbiter #(.NUM_MASTERS(N)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_m_wb_cyc (cyc),
        .i_m_wb_stb (stb),
        .i_m_wb_wen (wen),
        .i_m_wb_sel (sel),
        .i_m_wb_dat (dat),
        .i_m_wb_adr (adr),
        .i_m_wb_cti (cti),
        .o_m_wb_ack (o_m_wb_ack),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_wen   (o_wb_wen),
        .o_wb_sel   (o_wb_sel),
        .o_wb_dat   (o_wb_dat),
        .o_wb_adr   (o_wb_adr),
        .o_wb_cti   (o_wb_cti),
        .i_wb_ack   (wb_ack),
        .o_grant    (o_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cyc   = 1'b0;
        m_stb   = 1'b0;
        m_wen   = 1'b0;
        m_sel   = '0;
        m_dat   = '0;
        m_adr   = '0;
        m_cti   = '0;
    endtask

    task automatic model_copy(input int m);
        m_cyc = cyc[m];
        m_stb = stb[m];
        m_wen = wen[m];
        m_sel = sel[m];
        m_dat = dat[m];
        m_adr = adr[m];
        m_cti = cti[m];
    endtask

    // Compare at negedge, advance the model, then return just after the next posedge.
    task automatic step();
        logic       routed;
        logic [N-1:0] exp_ack, exp_grant;
        int         w;
        @(negedge clk);
        routed    = !rst && (m_owner >= 0) && m_stb && wb_ack;
        exp_ack   = routed ? (N'(1) << m_owner) : '0;
        exp_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        chk("ack",    o_m_wb_ack, exp_ack);
        chk("grant",  o_grant,    exp_grant);
        chk("cyc",    o_wb_cyc,   m_cyc);
        chk("stb",    o_wb_stb,   m_stb);
        chk("wen",    o_wb_wen,   m_wen);
        chk("sel",    o_wb_sel,   m_sel);
        chk("dat",    o_wb_dat,   m_dat);
        chk("adr",    o_wb_adr,   m_adr);
        chk("cti",    o_wb_cti,   m_cti);
        chk("busy",   dut.state == BUSY, m_owner >= 0);
        chk("rr_ptr", dut.rr_ptr, m_ptr);

        if (rst) begin
            model_reset();
        end else if (m_owner < 0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && stb[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            if (w >= 0) begin
                m_owner = w;
                model_copy(w);
            end
        end else if ((routed && (m_cti == CTI_CLASSIC || m_cti == CTI_EOB)) || !cyc[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_cyc   = 1'b0;
            m_stb   = 1'b0;
        end else begin
            model_copy(m_owner);
            if (routed) m_stb = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        cyc = '0; stb = '0; wen = '0; sel = '0; dat = '0; adr = '0; cti = '0;
    endtask

    task automatic set_req(input int m, input logic [2:0] c, input logic [31:0] a);
        cyc[m] = 1'b1;
        stb[m] = 1'b1;
        cti[m] = c;
        adr[m] = a;
        dat[m] = ~a;
        sel[m] = 4'hf;
        wen[m] = (m % 2 == 0);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        wb_ack = 1'b0;
        clear_in();
        step();
        rst = 1'b0;
    endtask

    int           acks;
    logic [N-1:0] active;

    initial begin
        rst    = 1'b1;
        wb_ack = 1'b0;
        clear_in();
        @(posedge clk);
        #1;
        model_reset();
        step();
        chk("rst_grant", o_grant, 0);
        chk("rst_cyc",   o_wb_cyc, 0);
        rst = 1'b0;

        // 1: single classic read from M0
        set_req(0, CTI_CLASSIC, 32'h1000_0000);
        step();
        chk("s1_stb",   o_wb_stb, 1);
        chk("s1_adr",   o_wb_adr, 32'h1000_0000);
        chk("s1_grant", o_grant, 4'b0001);
        step();
        wb_ack = 1'b1;
        #1;
        chk("s1_ack", o_m_wb_ack, 4'b0001);
        step();
        wb_ack = 1'b0;
        clear_in();
        chk("s1_cyc_off", o_wb_cyc, 0);
        chk("s1_ptr",     dut.rr_ptr, 1);
        step();

        // 2: four persistent classic requesters rotate with a dead cycle between grants
        do_reset();
        for (int m = 0; m < N; m++) set_req(m, CTI_CLASSIC, 32'h2000_0000 + m);
        step();
        for (int c = 1; c <= 9; c++) begin
            chk("s2_order", o_grant, (c % 2 == 1) ? (4'b0001 << (((c - 1) / 2) % N)) : 4'b0000);
            wb_ack = o_wb_stb;
            step();
        end
        wb_ack = 1'b0;
        clear_in();
        step();

        // 3: M1 4-beat INCR burst closed by EOB while M2 waits
        do_reset();
        set_req(1, CTI_INCR, 32'h3000_0000);
        set_req(2, CTI_CLASSIC, 32'h3100_0000);
        acks = 0;
        step();
        for (int c = 0; c < 20 && acks < 4; c++) begin
            cti[1] = (acks >= 3) ? CTI_EOB : CTI_INCR;
            adr[1] = 32'h3000_0000 + 32'(acks * 4);
            wb_ack = o_wb_stb;
            #1;
            if (o_m_wb_ack[1]) begin
                acks++;
                chk("s3_hold", o_grant, 4'b0010);
            end
            step();
        end
        chk("s3_beats", acks, 4);
        cyc[1] = 1'b0;
        stb[1] = 1'b0;
        wb_ack = 1'b0;
        chk("s3_dead", o_grant, 0);
        step();
        chk("s3_m2", o_grant, 4'b0100);
        clear_in();
        step();
        step();

        // 4: M3 abandons an INCR burst after two beats by dropping cyc
        do_reset();
        set_req(3, CTI_INCR, 32'h4000_0000);
        acks = 0;
        step();
        for (int c = 0; c < 10 && acks < 2; c++) begin
            wb_ack = o_wb_stb;
            #1;
            if (o_m_wb_ack[3]) acks++;
            step();
        end
        chk("s4_beats", acks, 2);
        cyc[3] = 1'b0;
        stb[3] = 1'b0;
        wb_ack = 1'b1;
        #1;
        chk("s4_noack", o_m_wb_ack, 0);
        step();
        chk("s4_idle", dut.state == IDLE, 1);
        chk("s4_ptr",  dut.rr_ptr, 0);
        #1;
        chk("s4_noack_idle", o_m_wb_ack, 0);
        wb_ack = 1'b0;
        step();

        // 5: reset while BUSY with an ack on the bus
        do_reset();
        set_req(0, CTI_INCR, 32'h5000_0000);
        step();
        wb_ack = 1'b1;
        rst    = 1'b1;
        #1;
        chk("s5_ack", o_m_wb_ack, 0);
        step();
        rst    = 1'b0;
        wb_ack = 1'b0;
        chk("s5_cyc",   o_wb_cyc, 0);
        chk("s5_stb",   o_wb_stb, 0);
        chk("s5_wen",   o_wb_wen, 0);
        chk("s5_sel",   o_wb_sel, 0);
        chk("s5_dat",   o_wb_dat, 0);
        chk("s5_adr",   o_wb_adr, 0);
        chk("s5_cti",   o_wb_cti, 0);
        chk("s5_grant", o_grant, 0);
        clear_in();
        step();

        // 6: stray acks while IDLE and in the stb-suppressed cycle
        do_reset();
        wb_ack = 1'b1;
        #1;
        chk("s6_idle_ack", o_m_wb_ack, 0);
        step();
        chk("s6_idle_state", dut.state == IDLE, 1);
        chk("s6_idle_ptr",   dut.rr_ptr, 0);
        wb_ack = 1'b0;
        set_req(0, CTI_INCR, 32'h6000_0000);
        step();
        wb_ack = 1'b1;
        step();
        #1;
        chk("s6_sup_stb", o_wb_stb, 0);
        chk("s6_sup_ack", o_m_wb_ack, 0);
        step();
        chk("s6_sup_grant", o_grant, 4'b0001);
        chk("s6_sup_ptr",   dut.rr_ptr, 0);
        wb_ack = 1'b0;
        clear_in();
        step();
        step();

        // Random traffic: masters go active/inactive, slave acks at random
        active = '0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(299) == 0);
            for (int m = 0; m < N; m++) begin
                if ($urandom_range(15) == 0) active[m] = ~active[m];
                if (active[m]) begin
                    cyc[m] = 1'b1;
                    stb[m] = ($urandom_range(3) != 0);
                    case ($urandom_range(3))
                        0:       cti[m] = CTI_CLASSIC;
                        3:       cti[m] = CTI_EOB;
                        default: cti[m] = CTI_INCR;
                    endcase
                end else begin
                    cyc[m] = 1'b0;
                    stb[m] = ($urandom_range(31) == 0);
                    cti[m] = 3'($urandom_range(7));
                end
                wen[m] = 1'($urandom_range(1));
                sel[m] = 4'($urandom_range(15));
                dat[m] = $urandom;
                adr[m] = $urandom;
            end
            wb_ack = 1'($urandom_range(1));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
